// File: rtl/buffer_pea_mode_switch.sv
// Registered mode switch between the two M1 buffer ports and the PE array.
// Each mode change drains in-flight PE results before the new controller takes over.
module buffer_pea_mode_switch #(
  parameter int                N_MODE       = 4,
  parameter int                N_BUF        = 8,
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 16,
  parameter int                CTRL_W       = 64,
  parameter logic [CTRL_W-1:0] CTRL_EN_MASK = '1,
  parameter int                DRAIN_CYC    = 4,
  localparam int               MW           = (N_MODE > 1) ? $clog2(N_MODE) : 1,
  localparam int               AW           = 2 * N_BUF * ADDR_W,
  localparam int               BW           = N_BUF * DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MW-1:0]            mode_req,
  input  logic                     mode_req_valid,
  output logic                     mode_req_ready,
  output logic [MW-1:0]            mode_active,
  output logic                     switching,
  output logic                     mode_err,
  input  logic                     pea_busy,
  input  logic [N_MODE-1:0]        swap_in,
  input  logic [N_MODE*2-1:0]      buf_r_en_in,
  input  logic [N_MODE*2-1:0]      buf_w_en_in,
  input  logic [N_MODE*AW-1:0]     buf_r_addr_in,
  input  logic [N_MODE*AW-1:0]     buf_w_addr_in,
  input  logic [N_MODE*CTRL_W-1:0] pea_ctrl_in,
  output logic [1:0]               buf_r_en,
  output logic [1:0]               buf_w_en,
  output logic [AW-1:0]            buf_r_addr,
  output logic [AW-1:0]            buf_w_addr,
  output logic [CTRL_W-1:0]        pea_ctrl,
  input  logic [BW-1:0]            buf1_rd_data,
  input  logic [BW-1:0]            buf2_rd_data,
  output logic [BW-1:0]            pea_in1,
  output logic [BW-1:0]            pea_in2,
  input  logic [BW-1:0]            pea_out,
  output logic [BW-1:0]            buf1_wr_data,
  output logic [BW-1:0]            buf2_wr_data
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  localparam int            CW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYC - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [MW-1:0] mode_tgt;
  logic          swap_sel;

  logic          req_bad;
  logic [MW-1:0] req_eff;
  logic          accept;
  logic          start;
  logic          drain_done;

  logic [1:0]        slot_r_en;
  logic [1:0]        slot_w_en;
  logic [AW-1:0]     slot_r_addr;
  logic [AW-1:0]     slot_w_addr;
  logic [CTRL_W-1:0] slot_ctrl;
  logic              tgt_swap;
  logic              gate;
  logic              zero;

  // Slot 0 is hard-wired IDLE; its input bits are deliberately never used.
  logic unused_slot0;
  assign unused_slot0 = ^{swap_in[0], buf_r_en_in[1:0], buf_w_en_in[1:0],
                          buf_r_addr_in[AW-1:0], buf_w_addr_in[AW-1:0],
                          pea_ctrl_in[CTRL_W-1:0]};

  assign mode_req_ready = (state == ST_RUN);
  assign switching      = (state != ST_RUN);

  assign req_bad    = {1'b0, mode_req} >= (MW+1)'(N_MODE);
  assign req_eff    = req_bad ? '0 : mode_req;
  assign accept     = mode_req_valid && mode_req_ready;
  assign start      = accept && (req_eff != mode_active);
  assign drain_done = (state == ST_DRAIN) && (cnt == CNT_LAST) && !pea_busy;

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    slot_r_en   = '0;
    slot_w_en   = '0;
    slot_r_addr = '0;
    slot_w_addr = '0;
    slot_ctrl   = '0;
    tgt_swap    = 1'b1;
    for (int m = 1; m < N_MODE; m++) begin
      if (mode_active == MW'(m)) begin
        slot_r_en   = buf_r_en_in[m*2 +: 2];
        slot_w_en   = buf_w_en_in[m*2 +: 2];
        slot_r_addr = buf_r_addr_in[m*AW +: AW];
        slot_w_addr = buf_w_addr_in[m*AW +: AW];
        slot_ctrl   = pea_ctrl_in[m*CTRL_W +: CTRL_W];
      end
      if (mode_tgt == MW'(m)) tgt_swap = swap_in[m];
    end
  end

  // Output registers look one state ahead so drain gating lands the cycle after accept.
  always_comb begin
    gate = 1'b0;
    zero = 1'b0;
    case (state)
      ST_RUN:   gate = start;
      ST_DRAIN: begin
        gate = !drain_done;
        zero = drain_done;
      end
      default:  zero = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cnt         <= '0;
      mode_tgt    <= '0;
      mode_active <= '0;
      swap_sel    <= 1'b1;
      mode_err    <= 1'b0;
      buf_r_en    <= '0;
      buf_w_en    <= '0;
      buf_r_addr  <= '0;
      buf_w_addr  <= '0;
      pea_ctrl    <= '0;
    end else begin
      mode_err   <= accept && req_bad;
      buf_r_en   <= (gate || zero) ? '0 : slot_r_en;
      buf_w_en   <= zero ? '0 : slot_w_en;
      buf_r_addr <= zero ? '0 : slot_r_addr;
      buf_w_addr <= zero ? '0 : slot_w_addr;
      pea_ctrl   <= zero ? '0 : (gate ? (slot_ctrl & ~CTRL_EN_MASK) : slot_ctrl);
      case (state)
        ST_RUN: begin
          if (start) begin
            state    <= ST_DRAIN;
            cnt      <= '0;
            mode_tgt <= req_eff;
          end
        end
        ST_DRAIN: begin
          if (drain_done)           state <= ST_SWITCH;
          else if (cnt != CNT_LAST) cnt   <= cnt + 1'b1;
        end
        ST_SWITCH: begin
          mode_active <= mode_tgt;
          swap_sel    <= tgt_swap;
          state       <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign pea_in1      = swap_sel ? buf1_rd_data : buf2_rd_data;
  assign pea_in2      = swap_sel ? buf2_rd_data : buf1_rd_data;
  assign buf1_wr_data = pea_out;
  assign buf2_wr_data = pea_out;

endmodule

// File: tb/tb_buffer_pea_mode_switch.sv
// Directed bench for buffer_pea_mode_switch: drain/switch timing, busy extension,
// no-op requests, swap path, mid-drain reset, and illegal-mode handling.
module tb_buffer_pea_mode_switch;

  localparam int          NM   = 4;
  localparam int          NB   = 2;
  localparam int          AWD  = 4;
  localparam int          DW   = 8;
  localparam int          CW   = 16;
  localparam int          DC   = 4;
  localparam logic [15:0] MASK = 16'h00FF;
  localparam int          AB   = 2 * NB * AWD;
  localparam int          BB   = NB * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       mode_req, mode_active;
  logic             valid, ready, switching, mode_err, pea_busy;
  logic [NM-1:0]    swap_in;
  logic [NM*2-1:0]  r_en_in, w_en_in;
  logic [NM*AB-1:0] r_addr_in, w_addr_in;
  logic [NM*CW-1:0] ctrl_in;
  logic [1:0]       r_en, w_en;
  logic [AB-1:0]    r_addr, w_addr;
  logic [CW-1:0]    pea_ctrl;
  logic [BB-1:0]    b1, b2, pin1, pin2, pout, wd1, wd2;

  buffer_pea_mode_switch #(
    .N_MODE(NM), .N_BUF(NB), .ADDR_W(AWD), .DATA_W(DW), .CTRL_W(CW),
    .CTRL_EN_MASK(MASK), .DRAIN_CYC(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mode_req(mode_req), .mode_req_valid(valid), .mode_req_ready(ready),
    .mode_active(mode_active), .switching(switching), .mode_err(mode_err),
    .pea_busy(pea_busy), .swap_in(swap_in),
    .buf_r_en_in(r_en_in), .buf_w_en_in(w_en_in),
    .buf_r_addr_in(r_addr_in), .buf_w_addr_in(w_addr_in), .pea_ctrl_in(ctrl_in),
    .buf_r_en(r_en), .buf_w_en(w_en), .buf_r_addr(r_addr), .buf_w_addr(w_addr),
    .pea_ctrl(pea_ctrl),
    .buf1_rd_data(b1), .buf2_rd_data(b2), .pea_in1(pin1), .pea_in2(pin2),
    .pea_out(pout), .buf1_wr_data(wd1), .buf2_wr_data(wd2)
  );

  // Second instance with three slots so mode 3 is out of range.
  logic [1:0]  req3, active3, r_en3, w_en3;
  logic        v3, ready3, sw3, err3;
  logic [2:0]  swap3;
  logic [5:0]  r_en_in3, w_en_in3;
  logic [23:0] r_addr_in3, w_addr_in3, ctrl_in3;
  logic [7:0]  r_addr3, w_addr3, ctrl3, pin1_3, pin2_3, wd1_3, wd2_3;

  buffer_pea_mode_switch #(
    .N_MODE(3), .N_BUF(1), .ADDR_W(4), .DATA_W(8), .CTRL_W(8), .DRAIN_CYC(2)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .mode_req(req3), .mode_req_valid(v3), .mode_req_ready(ready3),
    .mode_active(active3), .switching(sw3), .mode_err(err3),
    .pea_busy(1'b0), .swap_in(swap3),
    .buf_r_en_in(r_en_in3), .buf_w_en_in(w_en_in3),
    .buf_r_addr_in(r_addr_in3), .buf_w_addr_in(w_addr_in3), .pea_ctrl_in(ctrl_in3),
    .buf_r_en(r_en3), .buf_w_en(w_en3), .buf_r_addr(r_addr3), .buf_w_addr(w_addr3),
    .pea_ctrl(ctrl3),
    .buf1_rd_data(8'h11), .buf2_rd_data(8'h22), .pea_in1(pin1_3), .pea_in2(pin2_3),
    .pea_out(8'h33), .buf1_wr_data(wd1_3), .buf2_wr_data(wd2_3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ctrl_of(input int m);
    return (m == 0) ? 16'h0 : {4'(m), 4'hA, 4'hF, 4'(m)};
  endfunction
  function automatic logic [1:0] ren_of(input int m);
    return (m == 0) ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [1:0] wen_of(input int m);
    return 2'(m);
  endfunction
  function automatic logic [15:0] raddr_of(input int m);
    return (m == 0) ? 16'h0 : {4'(m), 12'h123};
  endfunction
  function automatic logic [15:0] waddr_of(input int m);
    return (m == 0) ? 16'h0 : {4'(m), 12'h987};
  endfunction

  task automatic switch_to(input logic [1:0] m);
    mode_req = m;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 40 && mode_active !== m; i++) tick();
    check("switch_to", mode_active, m);
    tick();
  endtask

  task automatic check_mode(input string tag, input int m);
    check({tag, "_ctrl"}, pea_ctrl, ctrl_of(m));
    check({tag, "_ren"}, r_en, ren_of(m));
    check({tag, "_wen"}, w_en, wen_of(m));
    check({tag, "_raddr"}, r_addr, raddr_of(m));
    check({tag, "_waddr"}, w_addr, waddr_of(m));
  endtask

  initial begin
    valid = 1'b0; mode_req = '0; pea_busy = 1'b0;
    v3 = 1'b0; req3 = '0;
    swap_in = 4'b0110;
    for (int m = 0; m < NM; m++) begin
      ctrl_in[m*CW +: CW]   = (m == 0) ? 16'hFFFF : ctrl_of(m);
      r_en_in[m*2 +: 2]     = 2'b11;
      w_en_in[m*2 +: 2]     = (m == 0) ? 2'b11 : wen_of(m);
      r_addr_in[m*AB +: AB] = (m == 0) ? 16'hFFFF : raddr_of(m);
      w_addr_in[m*AB +: AB] = (m == 0) ? 16'hFFFF : waddr_of(m);
    end
    swap3 = 3'b111;
    r_en_in3 = '1; w_en_in3 = '1; r_addr_in3 = 24'h5A5A5A; w_addr_in3 = 24'hA5A5A5;
    ctrl_in3 = {8'h32, 8'h31, 8'hFF};
    b1   = 16'($urandom);
    b2   = ~b1;
    pout = 16'($urandom);

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", pea_ctrl, 16'h0);
    check("rst_ren", r_en, 2'b00);
    check("rst_wen", w_en, 2'b00);
    check("rst_waddr", w_addr, 16'h0);
    check("rst_active", mode_active, 2'd0);
    #2 rst_n = 1'b1;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_switching", switching, 1'b0);
    check("rst_err", mode_err, 1'b0);
    check("rst_pea_in1", pin1, b1);
    check("rst_pea_in2", pin2, b2);
    check("wr_data1", wd1, pout);
    check("wr_data2", wd2, pout);

    // Mode 1 then normal drain to mode 2
    switch_to(2'd1);
    check_mode("m1", 1);
    mode_req = 2'd2;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    check("d1_ren", r_en, 2'b00);
    check("d1_ctrl", pea_ctrl, ctrl_of(1) & ~MASK);
    check("d1_wen", w_en, wen_of(1));
    check("d1_waddr", w_addr, waddr_of(1));
    check("d1_switching", switching, 1'b1);
    check("d1_ready", ready, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("dk_ren", r_en, 2'b00);
      check("dk_ctrl", pea_ctrl, ctrl_of(1) & ~MASK);
      check("dk_wen", w_en, wen_of(1));
      check("dk_switching", switching, 1'b1);
    end
    tick();
    check("sw_ctrl", pea_ctrl, 16'h0);
    check("sw_wen", w_en, 2'b00);
    check("sw_switching", switching, 1'b1);
    check("sw_active", mode_active, 2'd1);
    tick();
    check("t6_active", mode_active, 2'd2);
    check("t6_ready", ready, 1'b1);
    check("t6_switching", switching, 1'b0);
    check("t6_ctrl", pea_ctrl, 16'h0);
    tick();
    check_mode("m2", 2);

    // Drain extended by pea_busy: busy high through T+8, low from T+9
    pea_busy = 1'b1;
    mode_req = 2'd1;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check("busy_switching", switching, 1'b1);
      check("busy_ctrl", pea_ctrl, ctrl_of(2) & ~MASK);
      pea_busy = (k <= 8);
      tick();
    end
    check("busy_sw_ctrl", pea_ctrl, 16'h0);
    check("busy_sw_active", mode_active, 2'd2);
    check("busy_sw_switching", switching, 1'b1);
    tick();
    check("busy_t11_active", mode_active, 2'd1);
    check("busy_t11_switching", switching, 1'b0);
    tick();
    check_mode("busy_m1", 1);

    // No-op requests, back to back
    mode_req = 2'd1;
    valid    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("noop_ready", ready, 1'b1);
      check("noop_switching", switching, 1'b0);
      check("noop_ctrl", pea_ctrl, ctrl_of(1));
      check("noop_err", mode_err, 1'b0);
    end
    valid = 1'b0;
    tick();
    check_mode("noop_m1", 1);

    // Mode 3 uses the crossed data path
    switch_to(2'd3);
    check_mode("m3", 3);
    check("m3_pea_in1", pin1, b2);
    check("m3_pea_in2", pin2, b1);

    // Reset in the middle of a drain
    mode_req = 2'd1;
    valid    = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check("mid_switching", switching, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", pea_ctrl, 16'h0);
    check("mid_rst_wen", w_en, 2'b00);
    check("mid_rst_waddr", w_addr, 16'h0);
    check("mid_rst_active", mode_active, 2'd0);
    check("mid_rst_switching", switching, 1'b0);
    check("mid_rst_pea_in1", pin1, b1);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_ctrl", pea_ctrl, 16'h0);
    switch_to(2'd2);
    check_mode("post_rst_m2", 2);

    // Illegal mode on the three-slot instance
    req3 = 2'd1;
    v3   = 1'b1;
    tick();
    v3 = 1'b0;
    check("i3_ok_err", err3, 1'b0);
    for (int i = 0; i < 20 && active3 !== 2'd1; i++) tick();
    check("i3_active1", active3, 2'd1);
    tick();
    check("i3_ctrl1", ctrl3, 8'h31);
    req3 = 2'd3;
    v3   = 1'b1;
    tick();
    v3 = 1'b0;
    check("i3_err_pulse", err3, 1'b1);
    check("i3_switching", sw3, 1'b1);
    check("i3_drain_ctrl", ctrl3, 8'h00);
    check("i3_drain_ren", r_en3, 2'b00);
    tick();
    check("i3_err_clear", err3, 1'b0);
    for (int i = 0; i < 20 && !(active3 === 2'd0 && ready3 === 1'b1); i++) tick();
    check("i3_active0", active3, 2'd0);
    tick();
    check("i3_idle_ctrl", ctrl3, 8'h00);
    check("i3_idle_wen", w_en3, 2'b00);
    check("i3_idle_waddr", w_addr3, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_pea_mode_switch.md
# buffer_pea_mode_switch

Parametrised, registered mode switch between the two M1 buffer ports and the PE array: selects one of N_MODE controller control sets, with slot 0 hard-wired as IDLE. Mode changes use a valid/ready request. Each change runs a drain sequence so in-flight PE results are written back before the new controller takes ownership. Sits between the per-layer controllers (conv/dense/pool/...) and the buffer/PEA pair in the top level.

## Interface
- N_MODE, 4: number of control slots, including slot 0 (IDLE); MW = max(1, $clog2(N_MODE)).
- N_BUF, 8: buffer banks per port.
- ADDR_W, 10: per-bank address width.
- DATA_W, 16: per-lane data width.
- CTRL_W, 64: packed PEA control bundle width.
- CTRL_EN_MASK, all ones: bits of the PEA bundle forced to 0 during drain (enables/shifts).
- DRAIN_CYC, 4: minimum drain length in cycles, ≥1.
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- mode_req  in  MW  requested mode.
- mode_req_valid  in  1  request valid.
- mode_req_ready  out  1  request can be accepted.
- mode_active  out  MW  mode currently owning buffers/PEA.
- switching  out  1  high during DRAIN and SWITCH.
- mode_err  out  1  one-cycle pulse on an illegal request.
- pea_busy  in  1  PEA pipeline still holds results.
- swap_in  in  N_MODE  per-mode swap (1: PEA in1←buf1, in2←buf2; 0: crossed).
- buf_r_en_in, buf_w_en_in  in  N_MODE*2  per-mode read/write enables for {buf2, buf1}.
- buf_r_addr_in, buf_w_addr_in  in  N_MODE*2*N_BUF*ADDR_W  per-mode addresses.
- pea_ctrl_in  in  N_MODE*CTRL_W  per-mode PEA bundles.
- buf_r_en, buf_w_en  out  2  registered enables.
- buf_r_addr, buf_w_addr  out  2*N_BUF*ADDR_W  registered addresses.
- pea_ctrl  out  CTRL_W  registered PEA bundle.
- buf1_rd_data, buf2_rd_data  in  N_BUF*DATA_W  buffer read data.
- pea_in1, pea_in2  out  N_BUF*DATA_W  PEA input buses.
- pea_out  in  N_BUF*DATA_W  PEA output bus.
- buf1_wr_data, buf2_wr_data  out  N_BUF*DATA_W  both equal pea_out (combinational).

## Operation
- States: RUN, DRAIN, SWITCH.
- **RUN**
  - mode_req_ready = 1.
  - Control outputs register the mode_active slot.
  - Slot 0 always yields all-zero controls and swap = 1; slot-0 inputs are ignored.
- **Accept** (valid & ready):
  - mode_req == mode_active: no-op; stay in RUN.
  - mode_req ≥ N_MODE: mode_err pulses on the next cycle; the request is treated as mode 0.
  - Otherwise: go to DRAIN and load the drain counter to 0.
- **DRAIN**
  - Outputs keep the old mode's write enables and write addresses, so results land.
  - Read enables are forced to 0, and pea_ctrl bits under CTRL_EN_MASK are forced to 0.
  - Counter increments each cycle and saturates at DRAIN_CYC-1.
  - Exit to SWITCH when counter == DRAIN_CYC-1 and pea_busy == 0; otherwise hold.
- **SWITCH**
  - Lasts one cycle; all control outputs are 0.
  - mode_active and the registered swap select load the target at the end of the cycle.
  - Next state is RUN.
- Data path is combinational:
  - swap_sel comes from the registered swap of mode_active.
  - pea_in1/pea_in2 = buf1/buf2 read data when swap_sel = 1, crossed when swap_sel = 0.
- Reset (at any time, including mid-drain):
  - State goes to RUN, mode_active = 0, counter = 0.
  - All registered outputs = 0; switching = 0; mode_err = 0.
  - swap_sel = 1, and mode_req_ready = 1 from the first cycle after reset release.

## Timing
- Control latency: selected inputs at cycle t appear on the outputs at t+1.
- Accept at cycle T with pea_busy low:
  - Gated drain values are on the outputs from T+1.
  - switching and ready=0 hold over T+1 … T+DRAIN_CYC+1.
  - SWITCH occupies T+DRAIN_CYC+1.
  - mode_active is new and ready = 1 at T+DRAIN_CYC+2; the new mode's controls appear on the outputs from T+DRAIN_CYC+3.
- Each extra cycle of pea_busy high at the drain end extends DRAIN by one cycle.
- Request valid while ready = 0: not accepted. The requester holds valid until accepted.
- A no-op accept keeps ready high; back-to-back requests are allowed.

## Test plan
- Reset with random inputs → all outputs 0, mode_active = 0, swap_sel = 1, ready = 1, pea_in1 = buf1_rd_data.
- RUN mode 1, request mode 2 at T with DRAIN_CYC = 4 and pea_busy low → buf_r_en = 0 and masked bits 0 over T+1..T+4; buf_w_en still follows mode 1; all-zero controls at T+5; mode_active = 2 at T+6; mode 2 controls from T+7.
- Same as above with pea_busy high until T+9 → SWITCH at T+10, mode_active = 2 at T+11.
- Request the current mode → ready stays high, no switching pulse, outputs uninterrupted.
- With N_MODE = 3, request mode 3 → mode_err pulses at T+1; mode 0 is reached after the drain sequence; all outputs then 0.
- Assert rst_n low during DRAIN → immediate zero outputs and mode_active = 0; normal RUN after release. Mode 3 with swap_in[3] = 0 → pea_in1 = buf2_rd_data.
